// File: rtl/uart_buffered_transmitter.sv
// Byte-FIFO-fed UART transmitter (8 data bits, no parity, 1 or 2 stop bits).
// Bytes queue in a small power-of-two FIFO. Back-to-back frames are sent
// with no idle gap between them. The serial line output is registered.
module uart_buffered_transmitter #(
  parameter int BAUD_RATE       = 9600,
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int FIFO_DEPTH      = 16,
  parameter int STOP_BITS       = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          uart_transmit,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIVISOR   = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int STOP_CLKS = STOP_BITS * DIVISOR;
  localparam int CW        = $clog2(STOP_CLKS + 1);
  localparam int PW        = $clog2(FIFO_DEPTH);
  localparam int NW        = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [NW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            not_full;
  logic            push;
  logic            pop;

  // Ready is taken from the registered count only. A pop on the same edge
  // cannot make room for a push into a full FIFO.
  assign not_full   = (count_q < NW'(FIFO_DEPTH));
  assign in_ready   = reset | not_full;
  assign push       = in_valid & not_full & ~reset;
  assign busy       = (state_q != S_IDLE) | (count_q != '0);
  assign fifo_count = count_q;
  assign uart_transmit = tx_q;

  // FIFO storage: write at the tail on an accepted byte.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // FIFO pointers and occupancy. The pointers wrap naturally because the depth is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // Next-state logic. A pop happens from IDLE or at the end of STOP, and the
  // popped byte is loaded into the shift register.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
          baud_d  = '0;
        end
      end
      S_START: begin
        if (baud_q == CW'(DIVISOR - 1)) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d  = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_q == CW'(DIVISOR - 1)) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_q == CW'(STOP_CLKS - 1)) begin
          baud_d = '0;
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level follows the next state. The start bit therefore appears on
  // the same edge that pops the byte.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  // State register. Reset aborts any frame and discards queued bytes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: tb/tb_uart_buffered_transmitter.sv
// Scoreboard bench. The stimulus queues every accepted byte. A negedge
// monitor pops a byte when a frame starts and checks the waveform against a
// bit-per-DIVISOR line model. It also checks the count, ready and busy
// values that the queue implies.
module tb_uart_buffered_transmitter;
  localparam int DIV   = 10;
  localparam int DEPTH = 4;
  localparam int FR1   = 100;
  localparam int FR2   = 110;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset = 1'b1;
  logic [7:0] in_data, in_data2;
  logic       in_valid, in_valid2;
  logic       in_ready, in_ready2, tx, tx2, busy, busy2;
  logic [2:0] fifo_count, fifo_count2;

  uart_buffered_transmitter #(.BAUD_RATE(10), .CLOCK_FREQUENCY(100), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .uart_transmit(tx), .busy(busy), .fifo_count(fifo_count));

  uart_buffered_transmitter #(.BAUD_RATE(10), .CLOCK_FREQUENCY(100), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
    .clock(clock), .reset(reset), .in_data(in_data2), .in_valid(in_valid2), .in_ready(in_ready2),
    .uart_transmit(tx2), .busy(busy2), .fifo_count(fifo_count2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Line level at clock offset cyc within a frame carrying byte b
  function automatic logic exp_line(input logic [7:0] b, input int cyc);
    int idx;
    idx = cyc / DIV;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    return 1'b1;
  endfunction

  // Scoreboard state
  logic [7:0] exp_q[$];
  bit         in_frame = 0;
  bit         acc_last = 0;
  int         cyc = 0;
  int         bad = 0;
  logic [7:0] cur = '0;

  // Monitor: everything sampled on the falling edge
  always @(negedge clock) begin
    if (reset) begin
      chk("in_ready_during_reset", in_ready, 1);
      exp_q.delete();
      in_frame = 0;
      acc_last = 0;
    end else begin
      if (in_frame && cyc == FR1) begin
        chk("frame_bits", bad, 0);
        in_frame = 0;
        if (exp_q.size() > int'(acc_last)) chk("contiguous_start", tx, 0);
      end
      if (in_frame) begin
        if (tx !== exp_line(cur, cyc)) bad++;
        cyc++;
      end else if (tx !== 1'b1) begin
        if (exp_q.size() == 0) chk("spurious_frame", tx, 1);
        else begin
          cur = exp_q.pop_front();
          in_frame = 1;
          cyc = 1;
          bad = 0;
        end
      end
      chk("fifo_count", fifo_count, exp_q.size());
      chk("in_ready", in_ready, exp_q.size() < DEPTH);
      chk("busy", busy, in_frame || exp_q.size() != 0);
      acc_last = in_valid && in_ready;
      if (acc_last) exp_q.push_back(in_data);
    end
  end

  task automatic drive(input logic v, input logic [7:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 5000; k++) begin
      @(negedge clock);
      if (!busy && !in_frame && exp_q.size() == 0) break;
    end
    chk("drain_busy", busy, 0);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int ba, bb, bc;
    logic exp;
    in_valid = 1'b1; in_data = 8'hA5;   // held during reset; must not be stored
    in_valid2 = 1'b0; in_data2 = 8'h00;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    chk("reset_tx", tx, 1);
    chk("reset_count", fifo_count, 0);
    chk("reset_busy", busy, 0);
    @(posedge clock); #1;

    // Two stop bits: 0xFF then 0x00 back to back, 110-clock pitch
    in_valid2 = 1'b1; in_data2 = 8'hFF;
    @(posedge clock); #1 in_data2 = 8'h00;
    @(posedge clock); #1 in_valid2 = 1'b0;
    ba = 0; bb = 0; bc = 0;
    for (int i = 0; i < 2*FR2 + 20; i++) begin
      @(negedge clock);
      exp = (i < FR2) ? exp_line(8'hFF, i) : (i < 2*FR2) ? exp_line(8'h00, i - FR2) : 1'b1;
      if (tx2 !== exp) begin
        if (i < FR2) ba++; else if (i < 2*FR2) bb++; else bc++;
      end
      if (i == 0)         chk("sb2_count_first", fifo_count2, 1);
      if (i == FR2)       chk("sb2_count_second", fifo_count2, 0);
      if (i == 2*FR2 - 1) chk("sb2_busy_last_stop", busy2, 1);
      if (i == 2*FR2 + 1) chk("sb2_busy_after", busy2, 0);
    end
    chk("sb2_frame_ff", ba, 0);
    chk("sb2_frame_00", bb, 0);
    chk("sb2_idle_after", bc, 0);
    @(posedge clock); #1;

    // Single byte from idle: line falls one clock after acceptance
    drive(1'b1, 8'h41);
    @(negedge clock); chk("latency_accept_edge", tx, 1);
    @(negedge clock); chk("latency_next_edge", tx, 0);
    wait_drain();

    // Three consecutive pushes, then a push on the same edge as a pop at count 2
    drive(1'b1, 8'h11);
    drive(1'b1, 8'h22);
    drive(1'b1, 8'h33);
    idle(98);
    drive(1'b1, 8'h44);
    @(negedge clock); chk("push_pop_count2", fifo_count, 2);
    @(posedge clock); #1;
    wait_drain();

    // Overfill while a frame runs: two of six bytes are dropped
    drive(1'b1, 8'h60);
    for (int i = 1; i <= 6; i++) drive(1'b1, 8'h60 + 8'(i));
    @(negedge clock);
    chk("full_count", fifo_count, 4);
    chk("full_ready", in_ready, 0);
    @(posedge clock); #1;
    wait_drain();

    // Reset during data bit 3 of 0x55 with two bytes queued
    drive(1'b1, 8'h55);
    drive(1'b1, 8'hA1);
    drive(1'b1, 8'hA2);
    idle(40);
    reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("midframe_reset_tx", tx, 1);
    chk("midframe_reset_count", fifo_count, 0);
    chk("midframe_reset_busy", busy, 0);
    @(posedge clock); #1;
    idle(300);

    // Random traffic
    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 2) == 0, 8'($urandom));
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
